// File: rtl/repsig_stream_arbiter_if.sv
// Stream bundle between two sparse-stream producers, the arbiter and the shared
// RepeatSignalGenerator base_data_in port.
interface repsig_stream_arbiter_if #(
  parameter int DATA_W = 17
);
  logic [DATA_W-1:0] in0_data;
  logic              in0_valid;
  logic              in0_ready;
  logic [DATA_W-1:0] in1_data;
  logic              in1_valid;
  logic              in1_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_src;

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input  in0_ready, in1_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/repsig_stream_arbiter.sv
// Whole-stream round-robin arbiter: two requesters share one registered
// ready/valid output; a grant lasts from its first token through DONE_TOK.
module repsig_stream_arbiter #(
  parameter int                DATA_W   = 17,
  parameter logic [DATA_W-1:0] DONE_TOK = 17'h10100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   flush,
  input  logic                   tile_en,
  repsig_stream_arbiter_if.slave bus,
  output logic                   busy,
  output logic [15:0]            grant_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]        state;
  logic              owner;
  logic              rr_ptr;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p0;
  logic              src_p0;

  logic              space_p0;
  logic              rdy0;
  logic              rdy1;
  logic              acc;
  logic              drain;
  logic [DATA_W-1:0] acc_data;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    space_p0 = ~vld_p0 | bus.out_ready;
    rdy0     = (state == ST_GRANT) & ~owner & tile_en & space_p0;
    rdy1     = (state == ST_GRANT) &  owner & tile_en & space_p0;
    acc      = clk_en & ((rdy0 & bus.in0_valid) | (rdy1 & bus.in1_valid));
    acc_data = owner ? bus.in1_data : bus.in0_data;
    // While tile_en is low out_valid reads 0, so the datapath cannot take the token.
    drain    = clk_en & tile_en & vld_p0 & bus.out_ready;
  end

  assign bus.in0_ready = rdy0;
  assign bus.in1_ready = rdy1;
  assign bus.out_data  = data_p0;
  assign bus.out_valid = vld_p0 & tile_en;
  assign bus.out_src   = src_p0;
  assign busy          = (state == ST_GRANT);

  // Stage p0: output register, grant FSM and per-grant token counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      data_p0   <= '0;
      vld_p0    <= 1'b0;
      src_p0    <= 1'b0;
      grant_cnt <= 16'd0;
    end else if (clk_en) begin
      if (flush) begin
        state     <= ST_IDLE;
        owner     <= 1'b0;
        rr_ptr    <= 1'b0;
        data_p0   <= '0;
        vld_p0    <= 1'b0;
        src_p0    <= 1'b0;
        grant_cnt <= 16'd0;
      end else begin
        if (acc) begin
          data_p0 <= acc_data;
          src_p0  <= owner;
          vld_p0  <= 1'b1;
          if (acc_data == DONE_TOK) begin
            state     <= ST_IDLE;
            rr_ptr    <= ~owner;
            grant_cnt <= 16'd0;
          end else begin
            grant_cnt <= sat_inc(grant_cnt);
          end
        end else if (drain) begin
          vld_p0 <= 1'b0;
        end

        // The IDLE cycle only picks the owner; its first token is taken next cycle.
        if (state == ST_IDLE && tile_en) begin
          if (bus.in0_valid && bus.in1_valid) begin
            owner <= rr_ptr;
            state <= ST_GRANT;
          end else if (bus.in0_valid) begin
            owner <= 1'b0;
            state <= ST_GRANT;
          end else if (bus.in1_valid) begin
            owner <= 1'b1;
            state <= ST_GRANT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_repsig_stream_arbiter.sv
// Scoreboard bench for repsig_stream_arbiter: expected owner/word order is queued
// when streams are loaded and popped on every output handshake.
module tb_repsig_stream_arbiter;
  localparam logic [16:0] DONE = 17'h10100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        flush;
  logic        tile_en;
  logic        busy;
  logic [15:0] grant_cnt;

  repsig_stream_arbiter_if #(.DATA_W(17)) bus ();

  repsig_stream_arbiter #(.DATA_W(17), .DONE_TOK(17'h10100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .flush     (flush),
    .tile_en   (tile_en),
    .bus       (bus.slave),
    .busy      (busy),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  bit          f0[$];
  bit          f1[$];
  logic [17:0] expq[$];

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] cnt_m = 16'd0;
  bit          pend_v = 1'b0;
  logic [17:0] pend;
  bit          hold_v = 1'b0;
  logic [17:0] hold_val;
  bit          gap_en = 1'b0;
  bit          bp_en = 1'b0;
  bit          quiet = 1'b0;
  bit          no1_chk = 1'b0;
  int          acc0 = 0;
  int          acc1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input bit r, input logic [16:0] w, input bit first);
    if (r) begin q1.push_back(w); f1.push_back(first); end
    else   begin q0.push_back(w); f0.push_back(first); end
    expq.push_back({r, w});
  endtask

  task automatic gen_stream(input bit r, input int len);
    logic [16:0] w;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1)                 w = DONE;
      else if ($urandom_range(0, 3) == 0) w = {9'h100, 8'($urandom_range(0, 255))};
      else                              w = {1'b0, 16'($urandom)};
      push_word(r, w, i == 0);
    end
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); f0.delete(); f1.delete(); expq.delete();
    pend_v = 1'b0; hold_v = 1'b0; cnt_m = 16'd0;
  endtask

  // One clock: drive on the falling edge, sample 3 ns later, well before the rising edge.
  task automatic step();
    bit hs0, hs1, hso;
    logic [17:0] got, e;
    @(negedge clk);
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0_data  = '0;
    bus.in1_data  = '0;
    if (!quiet && q0.size() > 0) begin
      bus.in0_data = q0[0];
      if (!gap_en || f0[0] || $urandom_range(0, 3) != 0) bus.in0_valid = 1'b1;
    end
    if (!quiet && q1.size() > 0) begin
      bus.in1_data = q1[0];
      if (!gap_en || f1[0] || $urandom_range(0, 3) != 0) bus.in1_valid = 1'b1;
    end
    if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
    #3;
    got = {bus.out_src, bus.out_data};
    hs0 = bus.in0_valid & bus.in0_ready & clk_en;
    hs1 = bus.in1_valid & bus.in1_ready & clk_en;
    hso = bus.out_valid & bus.out_ready & clk_en;

    chk("ready_excl", {31'd0, bus.in0_ready & bus.in1_ready}, 0);
    if (no1_chk) chk("in1_ready_in_grant0", {31'd0, bus.in1_ready}, 0);
    if (!tile_en) begin
      chk("tile_rdy", {30'd0, bus.in0_ready, bus.in1_ready}, 0);
      chk("tile_valid", {31'd0, bus.out_valid}, 0);
    end
    if (pend_v && tile_en) begin
      chk("lat_valid", {31'd0, bus.out_valid}, 1);
      chk("lat_data", got, pend);
    end
    if (hold_v && tile_en) chk("hold_data", got, hold_val);
    chk("grant_cnt", grant_cnt, cnt_m);
    if (hso) begin
      if (expq.size() == 0) chk("extra_out", got, 18'h3FFFF);
      else begin
        e = expq.pop_front();
        chk("out_word", got, e);
      end
    end

    pend_v = 1'b0;
    if (hs0 || hs1) begin
      pend   = hs1 ? {1'b1, bus.in1_data} : {1'b0, bus.in0_data};
      pend_v = 1'b1;
      if (pend[16:0] == DONE) cnt_m = 16'd0;
      else if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      if (pend[16:0] == DONE) no1_chk = 1'b0;
    end
    if (hs0) begin void'(q0.pop_front()); void'(f0.pop_front()); acc0++; end
    if (hs1) begin void'(q1.pop_front()); void'(f1.pop_front()); acc1++; end
    hold_v   = bus.out_valid & ~bus.out_ready;
    hold_val = got;
    if (clk_en && flush) begin cnt_m = 16'd0; pend_v = 1'b0; hold_v = 1'b0; end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((q0.size() + q1.size() + expq.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    chk("run_drained", q0.size() + q1.size() + expq.size(), 0);
    if ((q0.size() + q1.size() + expq.size()) != 0) clear_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
    bus.in0_data = '0; bus.in0_valid = 1'b0;
    bus.in1_data = '0; bus.in1_valid = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cnt", grant_cnt, 0);
    chk("rst_data", {bus.out_src, bus.out_data}, 0);
    chk("rst_ready", {30'd0, bus.in0_ready, bus.in1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single stream from in0, then in1 must win the next contention (rr_ptr=1)
    push_word(1'b0, 17'h00003, 1'b1);
    push_word(1'b0, 17'h10000, 1'b0);
    push_word(1'b0, 17'h00005, 1'b0);
    push_word(1'b0, DONE, 1'b0);
    run(60);
    chk("single_busy_end", {31'd0, busy}, 0);
    gen_stream(1'b1, 2);
    gen_stream(1'b0, 2);
    run(60);

    // Contention straight from reset
    do_reset();
    no1_chk = 1'b1;
    push_word(1'b0, 17'h00001, 1'b1);
    push_word(1'b0, DONE, 1'b0);
    push_word(1'b1, 17'h00007, 1'b1);
    push_word(1'b1, DONE, 1'b0);
    run(60);
    no1_chk = 1'b0;

    // Fairness: three streams each, both always valid
    for (int i = 0; i < 3; i++) begin
      gen_stream(1'b0, 3 + i);
      gen_stream(1'b1, 2 + i);
    end
    run(200);

    // Backpressure with mid-stream valid gaps
    bp_en = 1'b1; gap_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      gen_stream(1'b0, $urandom_range(2, 9));
      gen_stream(1'b1, $urandom_range(2, 9));
    end
    run(600);
    bp_en = 1'b0; gap_en = 1'b0; bus.out_ready = 1'b1;

    // Mid-grant flush: rr_ptr is 1 beforehand, flush must restore priority to in0
    gen_stream(1'b0, 3);
    run(60);
    acc1 = 0;
    push_word(1'b1, 17'h00011, 1'b1);
    push_word(1'b1, 17'h00022, 1'b0);
    push_word(1'b1, 17'h00033, 1'b0);
    push_word(1'b1, 17'h00044, 1'b0);
    push_word(1'b1, DONE, 1'b0);
    for (int n = 0; n < 40 && acc1 < 2; n++) step();
    chk("flush_pre_acc", acc1, 2);
    flush = 1'b1; bus.out_ready = 1'b0;
    step();
    flush = 1'b0;
    clear_all();
    chk("flush_valid", {31'd0, bus.out_valid}, 0);
    chk("flush_busy", {31'd0, busy}, 0);
    chk("flush_cnt", grant_cnt, 0);
    bus.out_ready = 1'b1;
    gen_stream(1'b0, 2);
    gen_stream(1'b1, 2);
    run(60);

    // tile_en low for 5 cycles mid-stream
    acc0 = 0;
    gen_stream(1'b0, 8);
    for (int n = 0; n < 40 && acc0 < 2; n++) step();
    tile_en = 1'b0;
    repeat (5) step();
    tile_en = 1'b1;
    run(80);

    // clk_en low freezes everything, even with flush asserted
    acc1 = 0;
    gen_stream(1'b1, 6);
    for (int n = 0; n < 40 && acc1 < 2; n++) step();
    clk_en = 1'b0; flush = 1'b1; quiet = 1'b1; bus.out_ready = 1'b0;
    repeat (3) step();
    chk("clken_busy", {31'd0, busy}, 1);
    clk_en = 1'b1; flush = 1'b0; quiet = 1'b0; bus.out_ready = 1'b1;
    run(80);

    // Asynchronous reset between edges
    acc0 = 0;
    gen_stream(1'b0, 6);
    for (int n = 0; n < 40 && acc0 < 2; n++) step();
    chk("arst_pre_valid", {31'd0, bus.out_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_cnt", grant_cnt, 0);
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/repsig_stream_arbiter.md
Name: repsig_stream_arbiter

Overview:
- Shares one RepeatSignalGenerator base_data_in port between two sparse-stream producers (GLB readers or upstream scanners).
- Grants are whole-stream: a requester keeps the grant from its first accepted token up to and including its done token (17'h10100). Arbitration then moves round-robin.
- Output is one registered pipeline stage feeding the shared datapath's ready/valid port. A source tag identifies the owner of each output token.

Parameters:
- DATA_W, 17, stream word width; bit DATA_W-1 is the control-token flag.
- DONE_TOK, 17'h10100, token that closes a grant.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  clock enable; 0 freezes all state.
- flush  in  1  synchronous clear to reset state, qualified by clk_en.
- tile_en  in  1  0 forces all readies and out_valid to 0; state is held.
- in0_data  in  DATA_W  requester 0 stream word.
- in0_valid  in  1  requester 0 valid.
- in0_ready  out  1  requester 0 ready.
- in1_data  in  DATA_W  requester 1 stream word.
- in1_valid  in  1  requester 1 valid.
- in1_ready  out  1  requester 1 ready.
- out_data  out  DATA_W  to datapath base_data_in.
- out_valid  out  1  to datapath.
- out_ready  in  1  from datapath.
- out_src  out  1  owner of out_data.
- busy  out  1  a grant is active.
- grant_cnt  out  16  tokens accepted in the current grant; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n=0, async), and flush=1 at a clk_en edge, both produce: state=IDLE, out_valid=0, out_data=0, out_src=0, busy=0, grant_cnt=0, rr_ptr=0 (requester 0 has priority).
- States:
  - IDLE.
  - GRANT(owner).
- IDLE transitions:
  - Both valid: grant to rr_ptr.
  - One valid: grant to that requester.
  - Grant takes effect the next cycle. No token is accepted in the IDLE cycle (1-cycle arbitration bubble).
- GRANT(owner):
  - inX_ready = (X==owner) & tile_en & (~out_valid_reg | out_ready).
  - The non-owner's ready is 0.
- Acceptance:
  - Occurs when owner valid & ready.
  - On acceptance: the output register loads data, out_src=owner, out_valid=1, grant_cnt+1.
- Output register behaviour:
  - Latency is exactly 1 cycle from input acceptance to out_valid.
  - out_valid stays 1 and out_data is stable until out_ready.
  - Simultaneous drain and load in the same cycle is allowed, giving full throughput.
- End of grant:
  - Accepting DONE_TOK (exact 17-bit match) moves state to IDLE, sets rr_ptr=~owner, and clears grant_cnt.
  - The done token itself is still forwarded normally.
- Other control tokens (bit16=1, e.g. stop tokens 0x1_00LL) are forwarded and do not end the grant.
- busy = (state==GRANT).
- tile_en=0:
  - Readies and out_valid read 0.
  - The registered token, state and counters are retained and resume when tile_en returns to 1.
- clk_en=0: no state change and no acceptance. Readies are still gated combinationally by tile_en.
- Flush mid-grant discards the registered token and any partial stream. Requesters are responsible for flushing themselves.
- A requester that drops valid mid-stream keeps the grant. There is no timeout.

Test Plan:
- Single stream: in0 sends 0x00003, 0x10000, 0x00005, 0x10100 with out_ready=1 → out_data shows the same 4 words, each 1 cycle after acceptance; out_src=0; busy falls after the done token; rr_ptr=1.
- Contention: both valid from reset, in0 stream {0x1, 0x10100}, in1 stream {0x7, 0x10100} → output order 0x1, 0x10100, 0x7, 0x10100; out_src 0,0,1,1; in1_ready=0 throughout the in0 grant.
- Round-robin fairness: three back-to-back streams per requester, both always valid → grants alternate 0,1,0,1,0,1.
- Backpressure: out_ready randomly 0 → no word is lost or duplicated; out_data is stable while out_valid & ~out_ready; grant_cnt equals the words accepted.
- Mid-grant flush: after 2 words of in1, pulse flush → out_valid=0, busy=0, grant_cnt=0, next grant goes to in0 when both are valid.
- tile_en/async reset: tile_en=0 for 5 cycles mid-stream → readies and out_valid are 0, then the stream resumes intact. Asserting rst_n=0 between clock edges immediately clears out_valid and busy.
